// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Defaults suit a 16-bit datapath value feeding a 4-digit display.
package bin2bcd_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;
    localparam int DEF_SHOWN  = 4;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] din_i,
    output logic [BCD_W-1:0] dout_o
);

    always_comb begin
        dout_o = din_i;
        if (din_i >= ADD3_THRESH) begin
            dout_o = din_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter, one input bit per cycle. Produces
// packed BCD digits, a leading-zero blank mask and a display over-range flag.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS,
    parameter int SHOWN  = DEF_SHOWN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]       blank,
    output logic                    over
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = BCD_W * DIGITS;
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);
    localparam logic [DIGITS-1:0] BLANK_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  binSh_q, binSh_d;
    logic [BW-1:0]     bcdWork_q, bcdWork_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              over_q, over_d;

    logic [BW-1:0]     adjWork;
    logic [BW-1:0]     shiftedWork;
    logic [DIGITS-1:0] blankNext;
    logic              overNext;
    logic              allZero;

    genvar g;
    for (g = 0; g < DIGITS; g++) begin : genAdj
        bcd_digit_adj uAdj (
            .din_i  (bcdWork_q[BCD_W*g +: BCD_W]),
            .dout_o (adjWork[BCD_W*g +: BCD_W])
        );
    end

    assign shiftedWork = {adjWork[BW-2:0], binSh_q[WIDTH-1]};

    // Leading-zero mask and over-range flag are derived from the value being
    // committed on the final shift, so they always match the bcd they ship with.
    always_comb begin
        blankNext = '0;
        overNext  = 1'b0;
        allZero   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            allZero      = allZero & (shiftedWork[BCD_W*k +: BCD_W] == '0);
            blankNext[k] = allZero;
        end
        for (int k = SHOWN; k < DIGITS; k++) begin
            overNext = overNext | (shiftedWork[BCD_W*k +: BCD_W] != '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        binSh_d   = binSh_q;
        bcdWork_d = bcdWork_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        over_d    = over_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    binSh_d   = bin;
                    bcdWork_d = '0;
                    count_d   = COUNT_LOAD;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bcdWork_d = shiftedWork;
                binSh_d   = {binSh_q[WIDTH-2:0], 1'b0};
                count_d   = count_q - COUNT_ONE;
                if (count_q == COUNT_ONE) begin
                    bcd_d   = shiftedWork;
                    blank_d = blankNext;
                    over_d  = overNext;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            binSh_q   <= '0;
            bcdWork_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RESET;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            binSh_q   <= binSh_d;
            bcdWork_q <= bcdWork_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            over_q    <= over_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign blank = blank_q;
    assign over  = over_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed vector table plus hand-written multi-cycle sequences and a
// random sweep against a division-based decimal model.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        over;

    int nApplied;
    int nMiscompare;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic [4:0]  blank;
        logic        over;
    } vec_t;

    vec_t vecs[11];

    bin2bcd_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank),
        .over  (over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives start for one accepting edge; returns on the negedge after it.
    task automatic applyStimulus(input logic [15:0] value);
        @(negedge clk);
        start = 1'b1;
        bin   = value;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the negedge after the accepting edge; returns on the done negedge.
    task automatic waitDone(output int cyc, output int busyCnt);
        cyc     = 0;
        busyCnt = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busyCnt++;
        end
        if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
    endtask

    function automatic logic [19:0] modelBcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] modelBlank(input int v);
        logic [4:0] r;
        int p;
        r = '0;
        p = 10;
        for (int k = 1; k < 5; k++) begin
            r[k] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    initial begin
        int cyc;
        int busyCnt;
        int doneCnt;
        int v;

        vecs[0]  = '{16'h0000, 20'h00000, 5'b11110, 1'b0};
        vecs[1]  = '{16'h04D2, 20'h01234, 5'b10000, 1'b0};
        vecs[2]  = '{16'h270F, 20'h09999, 5'b10000, 1'b0};
        vecs[3]  = '{16'h2710, 20'h10000, 5'b00000, 1'b1};
        vecs[4]  = '{16'h0009, 20'h00009, 5'b11110, 1'b0};
        vecs[5]  = '{16'h000A, 20'h00010, 5'b11100, 1'b0};
        vecs[6]  = '{16'h0063, 20'h00099, 5'b11100, 1'b0};
        vecs[7]  = '{16'h0064, 20'h00100, 5'b11000, 1'b0};
        vecs[8]  = '{16'h03E8, 20'h01000, 5'b10000, 1'b0};
        vecs[9]  = '{16'h01F4, 20'h00500, 5'b11000, 1'b0};
        vecs[10] = '{16'hFFFF, 20'h65535, 5'b00000, 1'b1};

        nApplied    = 0;
        nMiscompare = 0;
        rst   = 1'b0;
        start = 1'b0;
        bin   = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy",  32'(busy),  32'd0);
        checkOutput("reset_done",  32'(done),  32'd0);
        checkOutput("reset_bcd",   32'(bcd),   32'h0);
        checkOutput("reset_blank", 32'(blank), 32'b11110);
        checkOutput("reset_over",  32'(over),  32'd0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].bin);
            waitDone(cyc, busyCnt);
            checkOutput($sformatf("latency[%0d]", i), 32'(cyc), 32'd16);
            checkOutput($sformatf("busy_cycles[%0d]", i), 32'(busyCnt), 32'd16);
            checkOutput($sformatf("bcd[%0d]", i), 32'(bcd), 32'(vecs[i].bcd));
            checkOutput($sformatf("blank[%0d]", i), 32'(blank), 32'(vecs[i].blank));
            checkOutput($sformatf("over[%0d]", i), 32'(over), 32'(vecs[i].over));
        end

        // Back-to-back: start issued during the done cycle of the 65535 run.
        start = 1'b1;
        bin   = 16'd7;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_done_one_cycle", 32'(done), 32'd0);
        waitDone(cyc, busyCnt);
        checkOutput("b2b_gap", 32'(cyc + 1), 32'd17);
        checkOutput("b2b_bcd", 32'(bcd), 32'h00007);
        checkOutput("b2b_blank", 32'(blank), 32'b11110);
        checkOutput("b2b_over", 32'(over), 32'd0);

        // Start held high with bin changing mid-conversion.
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd42;
        @(negedge clk);
        bin     = 16'd999;
        doneCnt = 0;
        cyc     = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) doneCnt++;
        end
        checkOutput("hold_latency", 32'(cyc), 32'd16);
        checkOutput("hold_done_count", 32'(doneCnt), 32'd1);
        checkOutput("hold_bcd", 32'(bcd), 32'h00042);
        checkOutput("hold_busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("hold_restart_busy", 32'(busy), 32'd1);
        checkOutput("hold_restart_done", 32'(done), 32'd0);
        waitDone(cyc, busyCnt);
        checkOutput("hold_second_bcd", 32'(bcd), 32'h00999);

        // Asynchronous reset in the middle of a conversion.
        applyStimulus(16'd500);
        repeat (6) @(negedge clk);
        checkOutput("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_busy",  32'(busy),  32'd0);
        checkOutput("midrst_done",  32'(done),  32'd0);
        checkOutput("midrst_bcd",   32'(bcd),   32'h0);
        checkOutput("midrst_blank", 32'(blank), 32'b11110);
        checkOutput("midrst_over",  32'(over),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(16'd500);
        waitDone(cyc, busyCnt);
        checkOutput("postrst_latency", 32'(cyc), 32'd16);
        checkOutput("postrst_bcd", 32'(bcd), 32'h00500);
        checkOutput("postrst_blank", 32'(blank), 32'b11000);

        // Random sweep against the decimal model.
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(0, 65535));
            applyStimulus(16'(v));
            waitDone(cyc, busyCnt);
            checkOutput($sformatf("rand_bcd[%0d]", v), 32'(bcd), 32'(modelBcd(v)));
            checkOutput($sformatf("rand_blank[%0d]", v), 32'(blank), 32'(modelBlank(v)));
            checkOutput($sformatf("rand_over[%0d]", v), 32'(over), 32'(v > 9999));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per cycle.
- Sits directly upstream of the seven-segment display stage. Takes the low 16 bits of the datapath result and produces decimal digits, a leading-zero blank mask and an over-range flag.
- The display stage then scans these outputs onto the 4-digit display.

Parameters:
- WIDTH, 16, binary input width.
- DIGITS, 5, BCD digits produced. Must satisfy DIGITS >= ceil(WIDTH*0.30103); for WIDTH=16 that is 5.
- SHOWN, 4, digits physically displayable; used for the over-range flag.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion; sampled only in IDLE.
- bin  in  WIDTH  binary value; captured on the edge that accepts start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse: bcd, blank and over are updated.
- bcd  out  4*DIGITS  packed BCD; digit 0 (units) is in bits [3:0].
- blank  out  DIGITS  1 = digit is a leading zero and should be blanked; bit 0 is always 0.
- over  out  1  value > 10^SHOWN - 1 (9999); the display cannot show it.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, count=0, working regs=0, busy=0, done=0, bcd=0, blank={DIGITS-1{1},0}, over=0. Effect is immediate, including mid-conversion; the partial result is discarded.
- States: IDLE, SHIFT.
- IDLE:
  - done is low except on the cycle immediately after a completion.
  - start=1 at a rising edge: load bin into the binary shift reg, clear the BCD working reg, count=WIDTH, go to SHIFT, busy=1.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - For every working digit >= 5, add 3 (4-bit, no carry out).
  - Then shift {bcd_work, bin_sh} left by 1; the MSB of bin_sh enters bit 0 of bcd_work.
  - Decrement count.
- SHIFT, final edge (count==1):
  - Write the shifted working value to bcd.
  - Compute blank and over from that value.
  - done<=1, busy<=0, state<=IDLE.
- Latency: start sampled at edge N gives done high during the cycle after edge N+WIDTH (16 cycles for defaults). bcd/blank/over change only at that edge and hold until the next completion or reset.
- done lasts exactly one cycle. start in the done cycle is accepted, so back-to-back conversions run at one per WIDTH+1 cycles.
- start while busy=1 is ignored; there is no queueing and bin changes have no effect mid-conversion.
- blank: bit k (k>=1) = 1 iff digits k..DIGITS-1 are all zero. Bit 0 is 0, so value 0 shows a single "0".
- over = 1 iff any digit at index >= SHOWN is nonzero.
- Add-3 is applied before the shift, never after the last shift, so no digit in bcd exceeds 9.
- count width is clog2(WIDTH+1). Working BCD reg is 4*DIGITS bits; overflow out of the top digit cannot occur given the DIGITS constraint.

Decomposition:
- Shared package:
  - state enum {IDLE, SHIFT};
  - default WIDTH/DIGITS/SHOWN constants;
  - ADD3_THRESH = 5;
  - BCD digit width = 4.
- One sub-module, bcd_digit_adj: combinational, 4-bit in, returns in+3 if in>=5 else in. Instantiate DIGITS times in a generate loop.
- FSM, counter, shift regs and output regs live in bin2bcd_seq.

Test Plan:
- bin=0x0000, start pulse -> done 16 cycles later; bcd=0x00000, blank=5'b11110, over=0; busy high exactly 16 cycles.
- bin=0x04D2 (1234) -> bcd=0x01234, blank=5'b10000, over=0. Then bin=0x270F (9999) -> bcd=0x09999, over=0. Then bin=0x2710 (10000) -> bcd=0x10000, over=1, blank=5'b00000.
- bin=0xFFFF (65535) -> bcd=0x65535, over=1. Issue a new start (bin=7) in the done cycle -> accepted; second done 17 cycles after the first; bcd=0x00007, blank=5'b11110.
- Start with bin=42, then hold start=1 and change bin=999 during busy -> exactly one done, bcd=0x00042; a second conversion begins only after return to IDLE.
- Start bin=500, assert rst low at cycle 7 -> busy/done/bcd/over go to 0 and blank to 5'b11110 immediately. Release rst, start bin=500 -> done after 16 cycles, bcd=0x00500, blank=5'b11000.
- Random sweep of 1000 values vs a reference model: bcd digits equal decimal digits of bin; over == (bin>9999); no digit > 9.
